// File: rtl/packet_rx.sv
// NoC receive endpoint: address filter, show-ahead FIFO,
// burst framing check and saturating drop counter.
module packet_rx #(
  parameter int                   WIDTH_TYPE    = 2,
  parameter int                   WIDTH_PAYLOAD = 8,
  parameter int                   WIDTH_PACKET  = 13,
  parameter int                   BURST_SIZE    = 1,
  parameter int                   FIFO_DEPTH    = 4,
  parameter logic [WIDTH_TYPE-1:0] LOCAL_ADDR   = 2'b01,
  parameter int                   CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH_PACKET-1:0]       pkt_in,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  output logic [WIDTH_TYPE-1:0]         dest_addr,
  output logic [WIDTH_TYPE-1:0]         pack_type,
  output logic [WIDTH_PAYLOAD-1:0]      payload,
  output logic                          eop,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          burst_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BURST_SIZE + 1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  logic [WIDTH_PACKET-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           level;
  logic                    full;
  logic                    empty;
  logic                    take;
  logic                    is_local;
  logic                    push;
  logic                    drop;
  logic                    pop;
  logic [WIDTH_PACKET-1:0] head;

  state_t                  state;
  state_t                  state_n;
  logic [BW-1:0]           cnt;
  logic [BW-1:0]           cnt_n;
  logic [BW-1:0]           beat_num;
  logic                    err_n;

  assign full      = (level == LW'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign pkt_ready = !full && !rst;
  assign take      = pkt_valid && pkt_ready;
  assign is_local  =
    (pkt_in[WIDTH_PACKET-1 -: WIDTH_TYPE] == LOCAL_ADDR);
  assign push      = take && is_local;
  assign drop      = take && !is_local;
  assign pop       = !empty && out_ready;

  assign out_valid  = !empty;
  assign fifo_level = level;
  assign head       = empty ? '0 : mem[rd_ptr];
  assign eop        = head[0];
  assign payload    = head[WIDTH_PAYLOAD:1];
  assign pack_type  = head[WIDTH_PAYLOAD+WIDTH_TYPE:WIDTH_PAYLOAD+1];
  assign dest_addr  = head[WIDTH_PACKET-1 -: WIDTH_TYPE];

  // Storage array; contents are don't-care until level says otherwise.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt_in;
  end

  // Pointers, occupancy and the saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop && (drop_count != '1))
        drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

  // Burst framing state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      burst_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      burst_err <= err_n;
    end
  end

  // Burst next-state: only accepted local beats advance the framing.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    err_n    = 1'b0;
    beat_num = (state == S_IDLE) ? BW'(1) : cnt + BW'(1);
    if (push) begin
      if (pkt_in[0]) begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end else if (beat_num == BW'(BURST_SIZE)) begin
        err_n   = 1'b1;
        state_n = S_IDLE;
        cnt_n   = '0;
      end else begin
        state_n = S_BURST;
        cnt_n   = beat_num;
      end
    end
  end

endmodule

// File: tb/tb_packet_rx.sv
// Directed bench for packet_rx with a scoreboard queue
// checked at every consumer pop.
module tb_packet_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] pkt_in;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [1:0]  dest_addr;
  logic [1:0]  pack_type;
  logic [7:0]  payload;
  logic        eop;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  drop_count;
  logic        burst_err;
  logic [2:0]  fifo_level;

  logic [12:0] p3_in;
  logic        p3_valid;
  logic        p3_ready;
  logic [1:0]  d3_addr;
  logic [1:0]  t3_type;
  logic [7:0]  pl3;
  logic        eop3;
  logic        ov3;
  logic        or3;
  logic [7:0]  drop3;
  logic        berr3;
  logic [2:0]  lvl3;

  logic [12:0] sb[$];
  int          exp_drop;
  int          n_tests;
  int          n_fail;

  always #5 clk = ~clk;

  packet_rx dut (
    .clk(clk), .rst(rst),
    .pkt_in(pkt_in), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .dest_addr(dest_addr), .pack_type(pack_type),
    .payload(payload), .eop(eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .drop_count(drop_count), .burst_err(burst_err),
    .fifo_level(fifo_level)
  );

  packet_rx #(.BURST_SIZE(3)) dut3 (
    .clk(clk), .rst(rst),
    .pkt_in(p3_in), .pkt_valid(p3_valid),
    .pkt_ready(p3_ready),
    .dest_addr(d3_addr), .pack_type(t3_type),
    .payload(pl3), .eop(eop3),
    .out_valid(ov3), .out_ready(or3),
    .drop_count(drop3), .burst_err(berr3),
    .fifo_level(lvl3)
  );

  function automatic logic [12:0] mk(
    input logic [1:0] d, input logic [1:0] t,
    input logic [7:0] p, input logic e);
    return {d, t, p, e};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One clock: score any pop, model pushes/drops, advance.
  task automatic tick();
    logic [12:0] e;
    if (rst) begin
      sb.delete();
      exp_drop = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pop_data",
              {19'd0, dest_addr, pack_type, payload, eop},
              {19'd0, e});
        end
      end
      if (pkt_valid && pkt_ready) begin
        if (pkt_in[12:11] == 2'b01) sb.push_back(pkt_in);
        else if (exp_drop < 255) exp_drop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_drop  = 0;
    rst       = 1'b1;
    pkt_in    = '0;
    pkt_valid = 1'b0;
    out_ready = 1'b0;
    p3_in     = '0;
    p3_valid  = 1'b0;
    or3       = 1'b1;
    #1;

    // 1: reset then single local beat
    repeat (5) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_berr", burst_err, 0);
    chk("rst_ready", pkt_ready, 0);
    chk("rst_fields", {dest_addr, pack_type, payload, eop}, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", pkt_ready, 1);
    pkt_in    = mk(2'b01, 2'b01, 8'hAB, 1'b1);
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_dest", dest_addr, 2'b01);
    chk("t1_type", pack_type, 2'b01);
    chk("t1_payload", payload, 8'hAB);
    chk("t1_eop", eop, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_popped", out_valid, 0);

    // 2: address mismatch drops and saturation
    pkt_valid = 1'b1;
    pkt_in    = mk(2'b10, 2'b10, 8'hCD, 1'b1);
    tick();
    pkt_in    = mk(2'b11, 2'b11, 8'hEF, 1'b1);
    tick();
    pkt_valid = 1'b0;
    chk("t2_drop2", drop_count, 2);
    chk("t2_no_valid", out_valid, 0);
    chk("t2_level", fifo_level, 0);
    pkt_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pkt_in = mk(2'(i % 3 == 0 ? 0 : i % 3 + 1),
                  2'(i), 8'(i), 1'b1);
      tick();
    end
    pkt_valid = 1'b0;
    chk("t2_sat", drop_count, 255);
    chk("t2_sat_model", drop_count, exp_drop);

    // 3: fill, hold fifth beat, no bypass on full
    pkt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pkt_in = mk(2'b01, 2'b00, 8'(i), 1'b1);
      tick();
    end
    chk("t3_level4", fifo_level, 4);
    chk("t3_full_ready", pkt_ready, 0);
    pkt_in = mk(2'b01, 2'b00, 8'h04, 1'b1);
    tick();
    chk("t3_held_level", fifo_level, 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_no_bypass", fifo_level, 3);
    chk("t3_ready_again", pkt_ready, 1);
    tick();
    pkt_valid = 1'b0;
    chk("t3_level_refill", fifo_level, 4);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    chk("t3_drained", fifo_level, 0);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: steady push+pop at level 2 with wrap
    pkt_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pkt_in = mk(2'b01, 2'b10, 8'h20 + 8'(i), 1'b1);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pkt_in = mk(2'b01, 2'b11, 8'h30 + 8'(i), 1'b1);
      tick();
      chk("t4_level2", fifo_level, 2);
    end
    pkt_valid = 1'b0;
    repeat (2) tick();
    out_ready = 1'b0;
    chk("t4_drained", fifo_level, 0);

    // 5: burst framing, BURST_SIZE=1 and 3
    chk("t5_berr_idle", burst_err, 0);
    pkt_in    = mk(2'b01, 2'b01, 8'h55, 1'b0);
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    chk("t5_berr_pulse", burst_err, 1);
    chk("t5_beat_kept", fifo_level, 1);
    tick();
    chk("t5_berr_once", burst_err, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    p3_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p3_in = mk(2'b01, 2'b00, 8'(i), i == 2);
      tick();
      chk("t5_b3_ok", berr3, 0);
    end
    for (int i = 0; i < 3; i++) begin
      p3_in = mk(2'b01, 2'b00, 8'(i), 1'b0);
      tick();
      chk("t5_b3_overrun", berr3, i == 2);
    end
    p3_valid = 1'b0;
    tick();
    chk("t5_b3_pulse_end", berr3, 0);

    // 6: reset with data and drops pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pkt_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pkt_in = mk(2'b01, 2'b01, 8'h60 + 8'(i), 1'b1);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      pkt_in = mk(2'b00, 2'b01, 8'h70, 1'b1);
      tick();
    end
    pkt_valid = 1'b0;
    chk("t6_level3", fifo_level, 3);
    chk("t6_drop5", drop_count, 5);
    rst = 1'b1;
    tick();
    chk("t6_valid0", out_valid, 0);
    chk("t6_level0", fifo_level, 0);
    chk("t6_drop0", drop_count, 0);
    chk("t6_ready0", pkt_ready, 0);
    tick();
    chk("t6_ready_hold", pkt_ready, 0);
    rst = 1'b0;
    #1;
    chk("t6_ready1", pkt_ready, 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
